// File: rtl/tcdm_mem_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_mem_model_pkg
// Description : Shared constants and helpers for the TCDM memory model:
//               LFSR seed/taps and next-state function, the out-of-range
//               read pattern and the width of the stall comparison.
// Revision    : 1.0 - initial release
// ============================================================================
package tcdm_mem_model_pkg;

    localparam logic [15:0] c_lfsr_seed   = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] c_lfsr_taps   = 16'hB400;
    localparam logic [31:0] c_dead_beef   = 32'hDEAD_BEEF;
    localparam int          c_stall_cmp_w = 8;

    // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & c_lfsr_taps)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tcdm_mem_model_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_mem_model_lfsr
// Description : 16-bit free-running Fibonacci LFSR used to draw per-port
//               grant stalls. Reset and clear both reload SEED.
// Ports       : clk_i, rst_i (async, active high), clear_i (sync reload),
//               lfsr_o - low c_stall_cmp_w bits of the current state
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_mem_model_lfsr
    import tcdm_mem_model_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    output logic [c_stall_cmp_w-1:0] lfsr_o
);

    logic [15:0] lfsr_d;
    logic [15:0] lfsr_q;

    always_comb begin
        lfsr_d = clear_i ? SEED : lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q[c_stall_cmp_w-1:0];

endmodule
`default_nettype wire

// File: rtl/tcdm_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_mem_model
// Description : Multi-port TCDM memory model. NP slave ports share one word
//               array; grants are stalled pseudo-randomly per port, every
//               transaction returns one r_valid pulse LATENCY cycles later,
//               out-of-range accesses return DEAD_BEEF and are counted.
// Ports       : clk_i, rst_i (async, active high), clear_i, stall_en_i,
//               tcdm_req/gnt/add/wen/be/data (request side, per port),
//               tcdm_r_data/r_valid (response side, per port),
//               cnt_rd_o/cnt_wr_o/cnt_err_o (saturating per-port counters)
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_mem_model
    import tcdm_mem_model_pkg::*;
#(
    parameter int              NP        = 3,
    parameter int              DW        = 32,
    parameter int              AW        = 32,
    parameter int              MEM_WORDS = 1024,
    parameter logic [AW-1:0]   BASE_ADDR = '0,
    parameter int              LATENCY   = 1,
    parameter int unsigned     STALL_TH  = 26,
    parameter int              CNT_W     = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic                          stall_en_i,
    input  logic [NP-1:0]                 tcdm_req,
    output logic [NP-1:0]                 tcdm_gnt,
    input  logic [NP-1:0][AW-1:0]         tcdm_add,
    input  logic [NP-1:0]                 tcdm_wen,
    input  logic [NP-1:0][DW/8-1:0]       tcdm_be,
    input  logic [NP-1:0][DW-1:0]         tcdm_data,
    output logic [NP-1:0][DW-1:0]         tcdm_r_data,
    output logic [NP-1:0]                 tcdm_r_valid,
    output logic [NP-1:0][CNT_W-1:0]      cnt_rd_o,
    output logic [NP-1:0][CNT_W-1:0]      cnt_wr_o,
    output logic [NP-1:0][CNT_W-1:0]      cnt_err_o
);

    localparam int OFFS_W = $clog2(DW/8);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int c_rep  = (DW + 31) / 32;
    localparam logic [c_rep*32-1:0] c_err_full = {c_rep{c_dead_beef}};
    localparam logic [DW-1:0]       c_err_word = c_err_full[DW-1:0];

    // Word array; deliberately never reset so it can be preloaded.
    logic [DW-1:0] mem [MEM_WORDS-1:0];

    logic [NP-1:0]            w_stall;
    logic [NP-1:0]            w_txn;
    logic [NP-1:0]            w_in_range;
    logic [NP-1:0][IDX_W-1:0] w_idx;
    logic [NP-1:0][DW-1:0]    w_rsp_word;

    logic [NP-1:0][LATENCY-1:0]         vld_d, vld_q;
    logic [NP-1:0][LATENCY-1:0][DW-1:0] dat_d, dat_q;
    logic [NP-1:0][CNT_W-1:0]           cnt_rd_d, cnt_rd_q;
    logic [NP-1:0][CNT_W-1:0]           cnt_wr_d, cnt_wr_q;
    logic [NP-1:0][CNT_W-1:0]           cnt_err_d, cnt_err_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    for (genvar p = 0; p < NP; p++) begin : g_port
        logic [c_stall_cmp_w-1:0] w_lfsr;
        logic [AW-1:0]            w_offs;

        tcdm_mem_model_lfsr #(
            .SEED (c_lfsr_seed ^ 16'(p + 1))
        ) u_lfsr (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .lfsr_o  (w_lfsr)
        );

        // Extra compare bit so a threshold of 256 means "always stall".
        assign w_stall[p] = stall_en_i & (STALL_TH != 0)
                          & ({1'b0, w_lfsr} < 9'(STALL_TH));
        assign tcdm_gnt[p] = tcdm_req[p] & ~w_stall[p];
        assign w_txn[p]    = tcdm_req[p] & tcdm_gnt[p];

        // The unsigned subtraction wraps below BASE_ADDR, hence the explicit
        // lower-bound test alongside the upper-bits-zero test.
        assign w_offs        = tcdm_add[p] - BASE_ADDR;
        assign w_in_range[p] = (tcdm_add[p] >= BASE_ADDR)
                             && ((w_offs >> (OFFS_W + IDX_W)) == '0);
        assign w_idx[p]      = w_offs[OFFS_W +: IDX_W];

        // Combinational array read gives the pre-write value on same-cycle
        // collisions with another port's write.
        assign w_rsp_word[p] = !tcdm_wen[p]   ? '0
                             : w_in_range[p]  ? mem[w_idx[p]]
                             :                  c_err_word;

        assign tcdm_r_valid[p] = vld_q[p][LATENCY-1];
        assign tcdm_r_data[p]  = dat_q[p][LATENCY-1];
    end

    // Ports are processed in ascending order so the highest index wins per
    // byte on same-word writes. Clear and reset leave the array alone.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NP; p++) begin
            if (w_txn[p] && !tcdm_wen[p] && w_in_range[p]) begin
                for (int bi = 0; bi < DW/8; bi++) begin
                    if (tcdm_be[p][bi]) begin
                        mem[w_idx[p]][bi*8 +: 8] <= tcdm_data[p][bi*8 +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        vld_d     = vld_q;
        dat_d     = dat_q;
        cnt_rd_d  = cnt_rd_q;
        cnt_wr_d  = cnt_wr_q;
        cnt_err_d = cnt_err_q;
        for (int p = 0; p < NP; p++) begin
            vld_d[p][0] = w_txn[p];
            dat_d[p][0] = w_txn[p] ? w_rsp_word[p] : '0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[p][i] = vld_q[p][i-1];
                dat_d[p][i] = dat_q[p][i-1];
            end
            if (w_txn[p]) begin
                if (tcdm_wen[p]) begin
                    cnt_rd_d[p] = sat_inc(cnt_rd_q[p]);
                end else begin
                    cnt_wr_d[p] = sat_inc(cnt_wr_q[p]);
                end
                if (!w_in_range[p]) begin
                    cnt_err_d[p] = sat_inc(cnt_err_q[p]);
                end
            end
        end
        // Clear drops in-flight responses and counters, never array writes.
        if (clear_i) begin
            vld_d     = '0;
            dat_d     = '0;
            cnt_rd_d  = '0;
            cnt_wr_d  = '0;
            cnt_err_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            dat_q     <= '0;
            cnt_rd_q  <= '0;
            cnt_wr_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            vld_q     <= vld_d;
            dat_q     <= dat_d;
            cnt_rd_q  <= cnt_rd_d;
            cnt_wr_q  <= cnt_wr_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    assign cnt_rd_o  = cnt_rd_q;
    assign cnt_wr_o  = cnt_wr_q;
    assign cnt_err_o = cnt_err_q;

endmodule
`default_nettype wire

// File: doc/tcdm_mem_model.md
# tcdm_mem_model

Parametrised multi-port TCDM memory model for HWPE test benches; successor to the fixed single-cycle dummy memory. Serves NP independent TCDM slave ports against one shared word array, with configurable read latency, LFSR-driven pseudo-random grant stalling, out-of-range detection and per-port read/write counters. Sits between the accelerator/core TCDM masters and the bench, replacing ad-hoc behavioural memories with a synthesizable, deterministic model.

## Interface
- NP, 3: number of TCDM slave ports (1..8)
- DW, 32: data width; byte enables are DW/8 bits
- AW, 32: address width (byte addresses)
- MEM_WORDS, 1024: array depth in DW-bit words (power of two)
- BASE_ADDR, 0: byte address of word 0
- LATENCY, 1: grant-to-r_valid cycles (1..4)
- STALL_TH, 26: stall when LFSR[7:0] < STALL_TH (26 ≈ 10 %); 0 disables stalling
- CNT_W, 32: counter width
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous clear of counters, pipeline and LFSRs (same values as reset)
- stall_en_i  in  1  global enable of random stalling
- tcdm_req  in  NP  request
- tcdm_gnt  out  NP  grant (combinational)
- tcdm_add  in  NP×AW  byte address
- tcdm_wen  in  NP  1 = read, 0 = write
- tcdm_be  in  NP×DW/8  byte enables
- tcdm_data  in  NP×DW  write data
- tcdm_r_data  out  NP×DW  read data
- tcdm_r_valid  out  NP  read/write response valid
- cnt_rd_o / cnt_wr_o / cnt_err_o  out  NP×CNT_W  per-port counters

## Operation
- Per port p: stall_p = stall_en_i & (STALL_TH != 0) & (lfsr_p[7:0] < STALL_TH); tcdm_gnt[p] = tcdm_req[p] & ~stall_p.
- lfsr_p: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle; reset/clear seed = 16'hACE1 ^ (p+1).
- Transaction occurs on req & gnt. Word index = (add − BASE_ADDR) >> log2(DW/8); in range iff add ≥ BASE_ADDR and index < MEM_WORDS.
- Write: bytes with be=1 updated at the granting edge; out-of-range writes dropped.
- Read: samples array at the granting edge (pre-write value if another port writes the same word that cycle); out-of-range reads return 32'hDEAD_BEEF (replicated for DW>32).
- Every transaction (read or write) produces exactly one r_valid pulse LATENCY cycles later; r_data meaningful only for reads, 0 for writes.
- Same-word simultaneous writes: higher port index wins per byte.
- Counters: cnt_rd/cnt_wr increment per granted read/write; cnt_err per out-of-range transaction (additionally to rd/wr); all saturate at all-ones.
- Array contents never reset or cleared; preloadable via $readmemh on hierarchical `mem`.

## Timing
- Reset: tcdm_r_valid=0, tcdm_r_data=0, all counters 0, LFSRs seeded; tcdm_gnt follows req combinationally (stall from seeded LFSR).
- Response pipeline per port: LATENCY-deep shift of {valid, data}; back-to-back grants yield back-to-back r_valid, no bubbles, no backpressure on r side.
- Reset/clear mid-operation: pending responses in the pipeline are discarded (never emitted); array writes already committed persist.
- clear_i and a grant in the same cycle: clear wins for counters and pipeline; the array write still commits.
- Counter increment and saturation in same cycle: value holds at all-ones.

## Structure
- Package tcdm_mem_model_pkg: LFSR seed/taps constants, DEAD_BEEF pattern, stall-compare width.
- Sub-module tcdm_mem_model_lfsr (one per port, generate loop); response pipeline and counters inline.
- Single array `mem` [MEM_WORDS-1:0][DW-1:0] written in port order within one always_ff.

## Test plan
- Reset then STALL_TH=0, LATENCY=1: port0 writes 32'h1234_5678 to 0x10, reads 0x10 -> r_valid one cycle after read grant, r_data 32'h1234_5678, cnt_wr[0]=1, cnt_rd[0]=1.
- be=4'b0011 write of 32'hFFFF_FFFF over 32'h0 -> readback 32'h0000_FFFF.
- LATENCY=3, 4 consecutive reads on port1 -> four consecutive r_valid starting 3 cycles after first grant, data in order.
- Ports 0 and 2 write 32'hA / 32'hB to same word same cycle, port1 reads it same cycle -> port1 gets old value; later read returns 32'hB.
- Read at BASE_ADDR+4*MEM_WORDS -> gnt, r_data 32'hDEAD_BEEF, cnt_err=1, cnt_rd=1; write there leaves array unchanged.
- stall_en_i=1, STALL_TH=26, 10 000 requests -> gnt deasserted 8–12 % of cycles, identical grant sequence across two runs; rst_i asserted with 2 reads in flight -> no r_valid after release.
